barrel_rotate_arbiter: RTL and testbench
========================================

// Module: barrel_rotate_arbiter
// PURPOSE
//  Shares one 3-stage right shift/rotate datapath (stage distances 4, 2, 1) between two requesters.
//  Round-robin arbitration picks a requester. The granted operand is sequenced through one stage per clock.
//  The result is held in an output register until the consumer accepts it.
//  Sits between two client blocks and any downstream consumer that needs shifted/rotated bytes.
// PARAMETERS
//  N    8  datapath width; fixed stage distances 4/2/1 require N=8
//  SHW  3  shift-amount width; log2(N)
// PORTS
//  clk         in   1    single clock, rising edge
//  rst_n       in   1    synchronous active-low reset
//  req0_valid  in   1    requester 0 has an operation
//  req0_ready  out  1    requester 0 operation accepted this cycle when valid&ready
//  req0_data   in   N    requester 0 operand
//  req0_shamt  in   SHW  requester 0 shift amount 0..7
//  req0_mode   in   1    0 = logical right shift (zero fill), 1 = rotate right
//  req1_*      -    -    identical set for requester 1
//  out_valid   out  1    result available
//  out_ready   in   1    consumer accepts result when valid&ready
//  out_data    out  N    shifted/rotated result
//  out_id      out  1    requester index that produced out_data
// BEHAVIOUR
//  - Reset (rst_n=0 at clk edge): state=IDLE, prio=0, out_valid=0, out_data=0, out_id=0, req*_ready=0 next cycle.
//    Reset applies regardless of state; an in-flight operation is discarded and never reported.
//  - FSM: IDLE -> ST4 -> ST2 -> ST1 -> DONE -> IDLE. No other transitions; no skipping when shamt bits are 0.
//  - IDLE: grant = the only valid requester; if both are valid, grant = prio.
//    reqX_ready = (state==IDLE) & (grant==X), combinational. Never both ready. Zero ready when neither is valid.
//  - Accept edge (valid&ready): latch data->work, shamt, mode, id; prio <= ~id; go to ST4.
//  - ST4: if shamt[2], work shifted right by 4; go to ST2.
//    ST2: if shamt[1], work shifted right by 2; go to ST1.
//    ST1: if shamt[0], work shifted right by 1; out_data<=result, out_id<=id, out_valid<=1; go to DONE.
//  - Fill bits: mode 0 zero-fills the vacated MSBs; mode 1 fills them with the bits shifted out of the LSBs.
//  - Latency: out_valid rises exactly 3 edges after the accepting edge. Throughput: at most 1 op per 5 cycles.
//  - DONE: out_data/out_id/out_valid are held stable while out_ready=0, for unbounded backpressure.
//    On the out_valid&out_ready edge: out_valid<=0 and go to IDLE. No new accept in that same cycle.
//  - While not in IDLE, req*_ready=0. Requester valids may toggle freely without effect.
//  - shamt=0 gives out_data=operand in both modes. Logical shift by 7 of 8'hFF gives 8'h01.
//  - out_data is only meaningful while out_valid=1. It keeps its last value after the handshake.
// STRUCTURE
//  - Package barrel_rotate_pkg:
//    state enum {IDLE,ST4,ST2,ST1,DONE};
//    MODE_SHR=1'b0, MODE_ROR=1'b1;
//    stage distance constants 4/2/1.
//  - Sub-module rot_stage (combinational): inputs in, en, mode, and distance as a parameter; output out.
//    Three instances (4/2/1). The FSM selects which instance result loads into work each cycle.
//  - The arbiter, prio flop, FSM and output register live in the top module.
// TESTING
//  1. Single req0: data=8'h10, shamt=4, mode=0, out_ready=1 -> out_data=8'h01, out_id=0, out_valid 3 edges after accept.
//  2. Rotate: req1 data=8'h81, shamt=1, mode=1 -> out_data=8'hC0, out_id=1. Then data=8'h81, shamt=7, mode=1 -> 8'h03.
//  3. Contention after reset: both valid, req0 data=8'hF0 shamt=4 mode=0, req1 data=8'h0F shamt=0 mode=0.
//     -> req0 served first (8'h0F, id 0), then req1 (8'h0F, id 1). Repeat contention -> req0 again (prio alternates).
//  4. Backpressure: out_ready=0 for 4 cycles after out_valid.
//     -> out_data/out_id stable, out_valid=1, req*_ready=0 throughout. Release -> one handshake, then IDLE.
//  5. Reset mid-op: assert rst_n=0 while in ST2 -> next cycle state IDLE, out_valid=0, prio=0, no result emitted.
//  6. Identity/zero-fill: shamt=0 on 8'hA5, both modes -> 8'hA5. Mode 0, shamt=7 on 8'hFF -> 8'h01.

Source files
------------

// File: rtl/barrel_rotate_arbiter_pkg.sv
// barrel_rotate_pkg: shared types and constants for the two-requester shift/rotate arbiter.
package barrel_rotate_pkg;
  localparam int N = 8;
  localparam int SHW = 3;
  localparam int DIST4 = 4;
  localparam int DIST2 = 2;
  localparam int DIST1 = 1;
  localparam logic MODE_SHR = 1'b0;
  localparam logic MODE_ROR = 1'b1;
  typedef enum logic [2:0] {IDLE, ST4, ST2, ST1, DONE} state_e;
endpackage

// File: rtl/barrel_rotate_arbiter_if.sv
// barrel_rotate_arbiter_if: two request channels plus the result channel.
interface barrel_rotate_arbiter_if;
  import barrel_rotate_pkg::*;
  logic req0_valid, req0_ready, req0_mode;
  logic [N-1:0] req0_data;
  logic [SHW-1:0] req0_shamt;
  logic req1_valid, req1_ready, req1_mode;
  logic [N-1:0] req1_data;
  logic [SHW-1:0] req1_shamt;
  logic out_valid, out_ready, out_id;
  logic [N-1:0] out_data;
  modport slave (
    input req0_valid, req0_data, req0_shamt, req0_mode,
    input req1_valid, req1_data, req1_shamt, req1_mode,
    input out_ready,
    output req0_ready, req1_ready, out_valid, out_data, out_id
  );
  modport master (
    output req0_valid, req0_data, req0_shamt, req0_mode,
    output req1_valid, req1_data, req1_shamt, req1_mode,
    output out_ready,
    input req0_ready, req1_ready, out_valid, out_data, out_id
  );
endinterface

// File: rtl/barrel_rotate_arbiter_rot_stage.sv
// rot_stage: one fixed-distance right shift/rotate stage, bypassed when en is low.
module rot_stage
  import barrel_rotate_pkg::*;
#(
  parameter int D = 1
) (
  input  logic [N-1:0] in,
  input  logic         en,
  input  logic         mode,
  output logic [N-1:0] out
);
  always_comb out = !en ? in : mode == MODE_ROR ? {in[D-1:0], in[N-1:D]} : in >> D;
endmodule

// File: rtl/barrel_rotate_arbiter.sv
// barrel_rotate_arbiter: round-robin sharing of a 4/2/1 staged shift/rotate datapath.
module barrel_rotate_arbiter
  import barrel_rotate_pkg::*;
(
  input logic clk,
  input logic rst_n,
  barrel_rotate_arbiter_if.slave bus
);
  state_e state_q, state_d;
  logic prio_q, prio_d, id_q, id_d, mode_q, mode_d;
  logic out_valid_q, out_valid_d, out_id_q, out_id_d;
  logic [SHW-1:0] shamt_q, shamt_d;
  logic [N-1:0] work_q, work_d, out_data_q, out_data_d, s4, s2, s1;
  logic idle, any, grant;
  assign idle = state_q == IDLE;
  assign any = bus.req0_valid | bus.req1_valid;
  assign grant = bus.req0_valid & bus.req1_valid ? prio_q : bus.req1_valid;
  assign bus.req0_ready = idle & any & ~grant;
  assign bus.req1_ready = idle & any & grant;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data = out_data_q;
  assign bus.out_id = out_id_q;
  rot_stage #(.D(DIST4)) u_st4 (.in(work_q), .en(shamt_q[2]), .mode(mode_q), .out(s4));
  rot_stage #(.D(DIST2)) u_st2 (.in(work_q), .en(shamt_q[1]), .mode(mode_q), .out(s2));
  rot_stage #(.D(DIST1)) u_st1 (.in(work_q), .en(shamt_q[0]), .mode(mode_q), .out(s1));
  always_comb begin
    state_d = state_q;
    prio_d = prio_q;
    id_d = id_q;
    mode_d = mode_q;
    shamt_d = shamt_q;
    work_d = work_q;
    out_valid_d = out_valid_q;
    out_data_d = out_data_q;
    out_id_d = out_id_q;
    case (state_q)
      IDLE: if (any) begin
        work_d = grant ? bus.req1_data : bus.req0_data;
        shamt_d = grant ? bus.req1_shamt : bus.req0_shamt;
        mode_d = grant ? bus.req1_mode : bus.req0_mode;
        id_d = grant;
        prio_d = ~grant;
        state_d = ST4;
      end
      ST4: begin
        work_d = s4;
        state_d = ST2;
      end
      ST2: begin
        work_d = s2;
        state_d = ST1;
      end
      ST1: begin
        work_d = s1;
        out_data_d = s1;
        out_id_d = id_q;
        out_valid_d = 1'b1;
        state_d = DONE;
      end
      DONE: if (bus.out_ready) begin
        out_valid_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      prio_q <= 1'b0;
      id_q <= 1'b0;
      mode_q <= MODE_SHR;
      shamt_q <= '0;
      work_q <= '0;
      out_valid_q <= 1'b0;
      out_data_q <= '0;
      out_id_q <= 1'b0;
    end else begin
      state_q <= state_d;
      prio_q <= prio_d;
      id_q <= id_d;
      mode_q <= mode_d;
      shamt_q <= shamt_d;
      work_q <= work_d;
      out_valid_q <= out_valid_d;
      out_data_q <= out_data_d;
      out_id_q <= out_id_d;
    end
  end
endmodule

// File: tb/tb_barrel_rotate_arbiter.sv
// tb_barrel_rotate_arbiter: directed and random checks against a transaction-level model.
module tb_barrel_rotate_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int tests = 0;
  int fails = 0;
  barrel_rotate_arbiter_if bif();
  barrel_rotate_arbiter dut (.clk(clk), .rst_n(rst_n), .bus(bif));
  always #5 clk = ~clk;
  int m_busy = 0;
  logic m_prio = 1'b0, m_ov = 1'b0, m_oid = 1'b0, m_pid = 1'b0, m_acc = 1'b0;
  logic [7:0] m_od = 8'h00, m_pend = 8'h00;
  function automatic logic [7:0] ref_op(logic [7:0] x, logic [2:0] s, logic m);
    logic [15:0] w;
    w = {x, x} >> s;
    return m ? w[7:0] : x >> s;
  endfunction
  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask
  task automatic check();
    logic g;
    g = bif.req0_valid & bif.req1_valid ? m_prio : bif.req1_valid;
    chk("ready0", bif.req0_ready, m_busy == 0 && bif.req0_valid && !g);
    chk("ready1", bif.req1_ready, m_busy == 0 && bif.req1_valid && g);
    chk("out_valid", bif.out_valid, m_ov);
    if (m_ov) begin
      chk("out_data", bif.out_data, m_od);
      chk("out_id", bif.out_id, m_oid);
    end
  endtask
  // Busy counts edges since the accept: 1..3 in flight, 4 holding a result.
  task automatic model_step();
    logic g;
    m_acc = 1'b0;
    if (!rst_n) begin
      m_busy = 0; m_prio = 1'b0; m_ov = 1'b0; m_od = 8'h00; m_oid = 1'b0;
    end else if (m_busy == 0) begin
      if (bif.req0_valid | bif.req1_valid) begin
        g = bif.req0_valid & bif.req1_valid ? m_prio : bif.req1_valid;
        m_pend = g ? ref_op(bif.req1_data, bif.req1_shamt, bif.req1_mode)
                   : ref_op(bif.req0_data, bif.req0_shamt, bif.req0_mode);
        m_pid = g; m_prio = !g; m_busy = 1; m_acc = 1'b1;
      end
    end else if (m_busy < 3) m_busy++;
    else if (m_busy == 3) begin
      m_ov = 1'b1; m_od = m_pend; m_oid = m_pid; m_busy = 4;
    end else if (bif.out_ready) begin
      m_ov = 1'b0; m_busy = 0;
    end
  endtask
  task automatic step();
    #1 check();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask
  task automatic set_req(input int ch, input logic v, input logic [7:0] d, input logic [2:0] s, input logic m);
    if (ch == 0) begin
      bif.req0_valid = v; bif.req0_data = d; bif.req0_shamt = s; bif.req0_mode = m;
    end else begin
      bif.req1_valid = v; bif.req1_data = d; bif.req1_shamt = s; bif.req1_mode = m;
    end
  endtask
  task automatic wait_acc(input int ch, input string nm);
    int n = 0;
    m_acc = 1'b0;
    while (!(m_acc && m_pid == ch) && n < 20) begin
      step();
      n++;
    end
    chk({nm, "_acc"}, n < 20, 1);
  endtask
  task automatic wait_out(input string nm, input logic [7:0] d, input logic id);
    int n = 0;
    while (!bif.out_valid && n < 20) begin
      step();
      n++;
    end
    chk({nm, "_lat"}, n, 3);
    chk({nm, "_data"}, bif.out_data, d);
    chk({nm, "_id"}, bif.out_id, id);
  endtask
  task automatic op(input string nm, input int ch, input logic [7:0] d, input logic [2:0] s,
                    input logic m, input logic [7:0] e);
    set_req(ch, 1'b1, d, s, m);
    wait_acc(ch, nm);
    set_req(ch, 1'b0, d, s, m);
    wait_out(nm, e, ch[0]);
    step();
  endtask
  task automatic contend(input string nm);
    set_req(0, 1'b1, 8'hF0, 3'd4, 1'b0);
    set_req(1, 1'b1, 8'h0F, 3'd0, 1'b0);
    wait_acc(0, {nm, "a"});
    wait_out({nm, "a"}, 8'h0F, 1'b0);
    step();
    wait_acc(1, {nm, "b"});
    wait_out({nm, "b"}, 8'h0F, 1'b1);
    bif.req0_valid = 1'b0;
    bif.req1_valid = 1'b0;
    step();
  endtask
  initial begin
    set_req(0, 1'b0, 8'h00, 3'd0, 1'b0);
    set_req(1, 1'b0, 8'h00, 3'd0, 1'b0);
    bif.out_ready = 1'b1;
    @(negedge clk);
    step();
    step();
    rst_n = 1'b1;
    chk("rst_out_valid", bif.out_valid, 0);
    chk("rst_out_data", bif.out_data, 0);
    chk("rst_out_id", bif.out_id, 0);
    op("shr4", 0, 8'h10, 3'd4, 1'b0, 8'h01);
    op("ror1", 1, 8'h81, 3'd1, 1'b1, 8'hC0);
    op("ror7", 1, 8'h81, 3'd7, 1'b1, 8'h03);
    op("id_shr", 0, 8'hA5, 3'd0, 1'b0, 8'hA5);
    op("id_ror", 1, 8'hA5, 3'd0, 1'b1, 8'hA5);
    op("shr7", 0, 8'hFF, 3'd7, 1'b0, 8'h01);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    contend("c1");
    contend("c2");
    set_req(0, 1'b1, 8'hB4, 3'd2, 1'b1);
    wait_acc(0, "bp");
    bif.req0_valid = 1'b0;
    bif.out_ready = 1'b0;
    wait_out("bp", 8'h2D, 1'b0);
    for (int i = 0; i < 4; i++) begin
      bif.req0_valid = 1'($urandom_range(0, 1));
      bif.req1_valid = 1'($urandom_range(0, 1));
      step();
      chk("bp_valid", bif.out_valid, 1);
      chk("bp_data", bif.out_data, 8'h2D);
      chk("bp_id", bif.out_id, 0);
      #1 chk("bp_ready", {bif.req0_ready, bif.req1_ready}, 0);
    end
    bif.req0_valid = 1'b0;
    bif.req1_valid = 1'b0;
    bif.out_ready = 1'b1;
    step();
    chk("bp_release", bif.out_valid, 0);
    step();
    set_req(0, 1'b1, 8'hFF, 3'd7, 1'b0);
    wait_acc(0, "mid");
    bif.req0_valid = 1'b0;
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      chk("mid_no_result", bif.out_valid, 0);
      step();
    end
    contend("c3");
    for (int i = 0; i < 3000; i++) begin
      set_req(0, 1'($urandom_range(0, 1)), 8'($urandom), 3'($urandom), 1'($urandom_range(0, 1)));
      set_req(1, 1'($urandom_range(0, 1)), 8'($urandom), 3'($urandom), 1'($urandom_range(0, 1)));
      bif.out_ready = $urandom_range(0, 3) != 0;
      rst_n = $urandom_range(0, 99) != 0;
      step();
    end
    rst_n = 1'b1;
    step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
